// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the MIPS fetch (IF) and data (MEM) ports.
// Build option MEM_ARB_FAIR_EN: lets a waiting fetch in after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic [1:0]  d_read,
  input  logic [1:0]  d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [2:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP_I, S_RESP_D} state_t;

  state_t      r_state;
  logic [1:0]  r_size;
  logic [1:0]  r_lo;
  logic [31:0] r_tcnt;

  logic        w_d_req;
  logic        w_d_wr;
  logic [1:0]  w_size;
  logic        w_misal;
  logic        w_grant_d;
  logic        w_tmo;
  logic        w_unused;

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b11:   f_be = 4'b1111;
      2'b10:   f_be = lo[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'b0001 << lo;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b11:   f_wdata = wd;
      2'b10:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = {4{wd[7:0]}};
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic [1:0] lo,
                                         input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b11:   f_load = word;
      2'b10:   f_load = 32'(h);
      default: f_load = 32'(b);
    endcase
  endfunction

  assign w_d_req  = (d_read != 2'b00) || (d_write != 2'b00);
  assign w_d_wr   = (d_write != 2'b00);
  assign w_size   = w_d_wr ? d_write : d_read;
  assign w_misal  = ((w_size == 2'b10) && d_addr[0]) ||
                    ((w_size == 2'b11) && (d_addr[1:0] != 2'b00));
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_unused = ^if_addr[1:0];

`ifdef MEM_ARB_FAIR_EN
  logic [31:0] r_streak;

  // Once the streak is used up a waiting fetch wins the next arbitration.
  assign w_grant_d = w_d_req && !(if_req && (r_streak == 32'(MAX_DATA_STREAK)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_streak <= '0;
    end else if ((r_state == S_IDLE) && if_req) begin
      if (w_grant_d) r_streak <= r_streak + 32'd1;
      else           r_streak <= '0;
    end
  end
`else
  localparam int unused_streak = MAX_DATA_STREAK;
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_size   <= '0;
      r_lo     <= '0;
      r_tcnt   <= '0;
      if_rdata <= '0;
      if_ready <= 1'b0;
      d_rdata  <= '0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_be     <= '0;
      m_wdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          if (w_grant_d) begin
            if (w_misal) begin
              d_rdata <= '0;
              d_err   <= 1'b1;
              d_ready <= 1'b1;
              r_state <= S_RESP_D;
            end else begin
              m_req   <= 1'b1;
              m_we    <= w_d_wr;
              m_addr  <= {d_addr[31:2], 2'b00};
              m_be    <= f_be(w_size, d_addr[1:0]);
              m_wdata <= f_wdata(w_size, d_wdata);
              r_size  <= w_size;
              r_lo    <= d_addr[1:0];
              r_state <= S_BUSY_D;
            end
          end else if (if_req) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= {if_addr[31:2], 2'b00};
            m_be    <= 4'b1111;
            r_state <= S_BUSY_I;
          end
        end
        S_BUSY_I: begin
          if (m_ack || w_tmo) begin
            m_req    <= 1'b0;
            if_rdata <= m_ack ? m_rdata : 32'h0;
            if_ready <= 1'b1;
            r_state  <= S_RESP_I;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_BUSY_D: begin
          if (m_ack) begin
            m_req   <= 1'b0;
            d_rdata <= m_we ? 32'h0 : f_load(r_size, r_lo, m_rdata);
            d_ready <= 1'b1;
            r_state <= S_RESP_D;
          end else if (w_tmo) begin
            m_req   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b1;
            d_ready <= 1'b1;
            r_state <= S_RESP_D;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported unified memory between the instruction-fetch (IF) port and the data (MEM) port of the MIPS pipeline.
- Data accesses use the same MemRead/MemWrite 2-bit size encoding the decoder produces: 11 word, 10 half, 01 byte, 00 none.
- Arbitrates the two ports, sequences the memory req/ack handshake, and generates byte enables and write-data replication.
- Returns sign-extended read data and signals completion to each port with a one-cycle ready pulse. The pipeline stalls a stage while its request is pending.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of BUSY cycles to wait for m_ack before aborting the access; 0 disables the timeout.
- MAX_DATA_STREAK, 4: number of consecutive data grants allowed while IF is waiting; used only with MEM_ARB_FAIR_EN.

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address, word aligned
- if_rdata  out  32  fetched word; valid while if_ready
- if_ready  out  1  fetch-complete pulse
- d_read  in  2  MemRead size code
- d_write  in  2  MemWrite size code
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  load data, sign-extended; valid while d_ready
- d_ready  out  1  data-complete pulse
- d_err  out  1  misaligned or timed-out access; valid while d_ready
- m_req  out  1  memory request
- m_we  out  1  write strobe
- m_addr  out  32  {addr[31:2],2'b00}
- m_be  out  4  byte enables, little-endian
- m_wdata  out  32  replicated store data
- m_rdata  in  32  memory read word
- m_ack  in  1  access complete; may arrive in the first m_req cycle

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; all outputs 0; streak and timeout counters 0. Reset during BUSY abandons the access with m_req dropped at once; the memory must tolerate this.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, grant priority:
  - A data request (d_read!=0 or d_write!=0) beats if_req.
  - If d_write!=0, the access is a write and d_read is ignored.
  - A misaligned data request (half with addr[0]=1, or word with addr[1:0]!=0) goes directly to RESP_D with d_err=1, d_rdata=0, and no memory access.
- On grant:
  - m_addr, m_be, m_we and m_wdata are registered at the grant edge.
  - m_req=1 from the next cycle and held stable until m_ack.
- Byte enables:
  - Word: 1111.
  - Half: addr[1] ? 1100 : 0011.
  - Byte: 1 << addr[1:0].
- Write data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- BUSY_x with m_ack=1: latch m_rdata; clear m_req; go to RESP_x.
- Load data for RESP_D:
  - Word: passed through unchanged.
  - Half: lane selected by addr[1], then sign-extended.
  - Byte: lane selected by addr[1:0], then sign-extended.
  - Write: d_rdata=0.
- Timeout: if BUSY lasts TIMEOUT_CYCLES cycles without m_ack, go to RESP_x with d_err=1 for data. A fetch timeout returns if_rdata=32'h0 (NOP).
- RESP_x: ready=1 for exactly one cycle, then IDLE. Requests are not sampled in RESP, so the requester may change its request during that cycle.
- Latency: grant edge, then m_req; an ack in the first m_req cycle gives ready 2 cycles after the request is first seen in IDLE. Minimum 3-cycle throughput per access.
- Simultaneous if_req and data request: data is served first and IF waits. When both are still pending after RESP_D, data wins again unless the fairness logic overrides.
- A requester dropping its request while in BUSY has no effect; the access completes normally.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined: a streak counter increments on each data grant while if_req=1 and clears on any IF grant. When the counter equals MAX_DATA_STREAK, the next IDLE arbitration with if_req=1 grants IF regardless of pending data.
- Undefined: strict data priority and no counter logic; IF may starve indefinitely.

Test Plan:
- lb at d_addr=0x1003, m_rdata=0x80FF_1234, m_ack immediate -> m_be=1000, d_ready 2 cycles after request, d_rdata=0xFFFF_FF80, d_err=0.
- sh d_addr=0x2002, d_wdata=0x0000_BEEF -> m_we=1, m_be=1100, m_wdata=0xBEEF_BEEF, m_addr=0x2000.
- lw at d_addr=0x2001 -> no m_req, d_ready pulse with d_err=1, d_rdata=0.
- if_req and lw asserted together, m_ack delayed 3 cycles -> data served first (d_ready), then IF (if_ready); each ready pulse exactly one cycle long.
- TIMEOUT_CYCLES=4 with m_ack held 0 on a fetch -> m_req deasserts after 4 BUSY cycles, if_ready=1, if_rdata=0; Rst_n pulsed low mid-BUSY -> m_req=0 immediately, state IDLE.
- MEM_ARB_FAIR_EN, MAX_DATA_STREAK=2, if_req held with continuous lw -> grant order D, D, I, D, D, I.
